// File: rtl/ksa_arbiter.sv
// Round-robin arbiter that time-shares one 32-bit Kogge-Stone adder among N_REQ
// requesters and registers each tagged result into a single backpressured response slot.

module ksa_top (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c0,
    output logic [31:0] o_sum,
    output logic        o_carry
);
    logic [31:0] prop;
    logic [31:0] g_cur, p_cur, g_nxt, p_nxt;

    assign prop = i_a ^ i_b;

    // Carry-in is folded into bit 0's generate so the prefix tree yields true carries.
    always_comb begin
        g_cur = (i_a & i_b) | {31'b0, prop[0] & i_c0};
        p_cur = prop;
        g_nxt = g_cur;
        p_nxt = p_cur;
        for (int l = 0; l < 5; l++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = (1 << l); i < 32; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
                p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
    end

    assign o_sum   = prop ^ {g_cur[30:0], i_c0};
    assign o_carry = g_cur[31];
endmodule

module ksa_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [32*N_REQ-1:0]   i_req_a,
    input  logic [32*N_REQ-1:0]   i_req_b,
    input  logic [N_REQ-1:0]      i_req_sub,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [31:0]           o_rsp_sum,
    output logic                  o_rsp_carry,
    output logic                  o_rsp_ovf
);
    logic [ID_W-1:0] ptr_reg, ptr_next, win_id;
    logic [ID_W:0]   idx_ext;
    logic            found, slot_free, accept;
    logic [31:0]     a_arr [N_REQ];
    logic [31:0]     b_arr [N_REQ];
    logic [31:0]     a_sel, b_sel, b_eff, sum;
    logic            sub_sel, carry, ovf;

    logic            rsp_valid_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic [31:0]     rsp_sum_reg;
    logic            rsp_carry_reg, rsp_ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi]       = i_req_a[32*gi +: 32];
            assign b_arr[gi]       = i_req_b[32*gi +: 32];
            assign o_req_ready[gi] = accept && (win_id == ID_W'(gi));
        end
    endgenerate

    assign slot_free = !rsp_valid_reg || i_rsp_ready;

    // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        win_id  = '0;
        idx_ext = '0;
        for (int j = 0; j < N_REQ; j++) begin
            idx_ext = {1'b0, ptr_reg} + (ID_W+1)'(j);
            if (idx_ext >= (ID_W+1)'(N_REQ))
                idx_ext = idx_ext - (ID_W+1)'(N_REQ);
            if (!found && i_req_valid[idx_ext[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = idx_ext[ID_W-1:0];
            end
        end
    end

    assign accept  = found && slot_free && i_rst_n;
    assign a_sel   = a_arr[win_id];
    assign b_sel   = b_arr[win_id];
    assign sub_sel = i_req_sub[win_id];
    assign b_eff   = sub_sel ? ~b_sel : b_sel;

    ksa_top u_ksa (
        .i_a     (a_sel),
        .i_b     (b_eff),
        .i_c0    (sub_sel),
        .o_sum   (sum),
        .o_carry (carry)
    );

    assign ovf = (a_sel[31] == b_eff[31]) && (sum[31] != a_sel[31]);

    always_comb begin
        ptr_next = ptr_reg;
        if (accept)
            ptr_next = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (accept) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= win_id;
                rsp_sum_reg   <= sum;
                rsp_carry_reg <= carry;
                rsp_ovf_reg   <= ovf;
            end else if (i_rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_id    = rsp_id_reg;
    assign o_rsp_sum   = rsp_sum_reg;
    assign o_rsp_carry = rsp_carry_reg;
    assign o_rsp_ovf   = rsp_ovf_reg;
endmodule

// File: tb/tb_ksa_arbiter.sv
// Bench for ksa_arbiter: directed scenarios plus randomized traffic against a
// behavioural model (round-robin list scan and wide integer arithmetic).

module tb_ksa_arbiter;
    localparam int N = 4;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]   req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_sum;
    logic           rsp_carry, rsp_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    logic [1:0]  m_id;
    logic [31:0] m_sum;
    logic        m_carry, m_ovf;
    int          last_grant;

    wire [36:0] dut_rsp = {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf};

    always #5 clk = ~clk;

    ksa_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_sub   (req_sub),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_carry (rsp_carry),
        .o_rsp_ovf   (rsp_ovf)
    );

    function automatic int exp_winner();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int j = 0; j < N; j++) begin
            int k = (m_ptr + j) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        int w = exp_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // Returns {ovf, carry, sum} from plain integer arithmetic.
    function automatic logic [33:0] model_op(logic [31:0] a, logic [31:0] b, logic sub);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint rs, ru;
        logic [31:0] s;
        logic c, o;
        if (sub) begin
            s  = a - b;
            c  = (ua >= ub);
            rs = sa - sb;
        end else begin
            ru = ua + ub;
            s  = ru[31:0];
            c  = (ru >= 64'h1_0000_0000);
            rs = sa + sb;
        end
        o = (rs > S_MAX) || (rs < S_MIN);
        return {o, c, s};
    endfunction

    function automatic logic [36:0] exp_rsp();
        return {m_valid, m_id, m_sum, m_carry, m_ovf};
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        int w;
        logic [33:0] r;
        w = exp_winner();
        @(posedge clk);
        last_grant = -1;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ovf = 0;
        end else if (w >= 0) begin
            r = model_op(req_a[w*32 +: 32], req_b[w*32 +: 32], req_sub[w]);
            m_valid = 1; m_id = 2'(w); m_sum = r[31:0]; m_carry = r[32]; m_ovf = r[33];
            m_ptr = (w + 1) % N;
            last_grant = w;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = '1; rsp_ready = 1; req_sub = '0;
        req_a = '0; req_b = '0;
        tick();
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        tests_run++;
        if (dut_rsp !== 37'b0) begin
            tests_failed++; $display("FAIL reset_rsp: got %h expected 0", dut_rsp);
        end
        rst_n = 1; #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        req_valid = '0; #1;
    endtask

    task automatic test_add();
        req_valid = 4'b0001; req_a[31:0] = 32'd5; req_b[31:0] = 32'd3; req_sub = '0; rsp_ready = 1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL add_ready: got %b expected 0001", req_ready);
        end
        tick();
        tests_run++;
        if (dut_rsp !== {1'b1, 2'd0, 32'd8, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL add_rsp: got %h expected %h", dut_rsp, {1'b1, 2'd0, 32'd8, 1'b0, 1'b0});
        end
        req_valid = '0;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL add_drain: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_sub_ovf();
        logic [31:0] ta [3] = '{32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [3] = '{32'd5, 32'd1, 32'd1};
        logic        ts [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] es [3] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h0};
        logic        ec [3] = '{1'b0, 1'b0, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b0};
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0100; req_a[64 +: 32] = ta[i]; req_b[64 +: 32] = tb[i]; req_sub[2] = ts[i];
            #1;
            tests_run++;
            if (req_ready !== 4'b0100) begin
                tests_failed++; $display("FAIL subovf_ready[%0d]: got %b expected 0100", i, req_ready);
            end
            tick();
            tests_run++;
            if (dut_rsp !== {1'b1, 2'd2, es[i], ec[i], eo[i]}) begin
                tests_failed++; $display("FAIL subovf_rsp[%0d]: got %h expected %h", i, dut_rsp, {1'b1, 2'd2, es[i], ec[i], eo[i]});
            end
        end
        req_valid = '0; req_sub = '0;
        tick();
    endtask

    task automatic test_rotation();
        logic [N-1:0] e;
        rst_n = 0; tick(); rst_n = 1;
        req_valid = '1; rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                req_a[k*32 +: 32] = rand_operand(); req_b[k*32 +: 32] = rand_operand();
                req_sub[k] = 1'($urandom_range(0, 1));
            end
            #1;
            e = 4'b0001 << (i % N);
            tests_run++;
            if (req_ready !== e) begin
                tests_failed++; $display("FAIL rotation_ready[%0d]: got %b expected %b", i, req_ready, e);
            end
            tick();
            tests_run++;
            if (dut_rsp !== exp_rsp() || rsp_id !== 2'(i % N)) begin
                tests_failed++; $display("FAIL rotation_rsp[%0d]: got %h expected %h", i, dut_rsp, exp_rsp());
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [36:0] snap;
        req_valid = 4'b0010; rsp_ready = 1; req_sub = '0;
        req_a[32 +: 32] = 32'h1234_5678; req_b[32 +: 32] = 32'h1111_1111;
        #1;
        tick();
        tests_run++;
        if (dut_rsp !== exp_rsp() || rsp_id !== 2'd1) begin
            tests_failed++; $display("FAIL bp_setup: got %h expected %h", dut_rsp, exp_rsp());
        end
        snap = dut_rsp;
        rsp_ready = 0; req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, req_ready);
            end
            tick();
            tests_run++;
            if (dut_rsp !== snap) begin
                tests_failed++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, dut_rsp, snap);
            end
        end
        rsp_ready = 1; #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL bp_release_ready: got %b expected 0100", req_ready);
        end
        tick();
        tests_run++;
        if (dut_rsp !== exp_rsp() || rsp_id !== 2'd2) begin
            tests_failed++; $display("FAIL bp_release_rsp: got %h expected %h", dut_rsp, exp_rsp());
        end
        req_valid = '0;
    endtask

    task automatic test_ptr_skip();
        logic [N-1:0] seq [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        rsp_ready = 1;
        req_valid = 4'b0010; #1; tick();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (req_ready !== seq[i]) begin
                tests_failed++; $display("FAIL skip_ready[%0d]: got %b expected %b", i, req_ready, seq[i]);
            end
            tick();
            tests_run++;
            if (dut_rsp !== exp_rsp()) begin
                tests_failed++; $display("FAIL skip_rsp[%0d]: got %h expected %h", i, dut_rsp, exp_rsp());
            end
        end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        rsp_ready = 0; req_valid = 4'b0001; #1;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_setup: got valid=%b expected 1", rsp_valid);
        end
        rst_n = 0; tick();
        tests_run++;
        if (dut_rsp !== 37'b0 || req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL midrst_clear: got rsp=%h ready=%b expected 0/0000", dut_rsp, req_ready);
        end
        rst_n = 1; rsp_ready = 1; req_valid = '1; #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready);
        end
        req_valid = 4'b1000; #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL midrst_req3_ready: got %b expected 1000", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || dut_rsp !== exp_rsp()) begin
            tests_failed++; $display("FAIL midrst_req3_rsp: got %h expected %h", dut_rsp, exp_rsp());
        end
        req_valid = '0; tick();
    endtask

    task automatic test_random();
        logic [N-1:0] obs;
        int waits [N];
        for (int k = 0; k < N; k++) waits[k] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    req_valid[k] = 1'b1;
                    req_a[k*32 +: 32] = rand_operand();
                    req_b[k*32 +: 32] = rand_operand();
                    req_sub[k] = 1'($urandom_range(0, 1));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            obs = req_ready;
            tests_run++;
            if (obs !== exp_ready()) begin
                tests_failed++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, obs, exp_ready());
            end
            for (int k = 0; k < N; k++) begin
                if (obs[k]) begin
                    tests_run++;
                    if (waits[k] > N - 1) begin
                        tests_failed++; $display("FAIL rand_fair[%0d]: req %0d waited %0d accepts, limit %0d", c, k, waits[k], N - 1);
                    end
                    waits[k] = 0;
                end else if (req_valid[k] && obs != '0) begin
                    waits[k]++;
                end
            end
            tick();
            tests_run++;
            if (dut_rsp !== exp_rsp()) begin
                tests_failed++; $display("FAIL rand_rsp[%0d]: got %h expected %h", c, dut_rsp, exp_rsp());
            end
            for (int k = 0; k < N; k++)
                if (obs[k]) req_valid[k] = 1'b0;
        end
        req_valid = '0;
    endtask

    initial begin
        m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ovf = 0; last_grant = -1;
        rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 0;
        test_reset();
        test_add();
        test_sub_ovf();
        test_rotation();
        test_backpressure();
        test_ptr_skip();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ksa_arbiter.md
# ksa_arbiter

Round-robin arbiter that shares one 32-bit Kogge-Stone adder instance (`ksa_top`) among N_REQ requesters in the FFT butterfly datapath. Each requester hands over one add or subtract per valid/ready handshake. The block drives the shared adder with the granted operands and registers the result, tagged with the requester ID, into a single-entry response slot. The slot is backpressured by the downstream consumer.

## Interface
- N_REQ, 4 — number of requesters; legal range 2..8.
- ID_W, 2 — requester ID width, equal to clog2(N_REQ).
- i_clk  in  1  — single clock; all state updates on the rising edge.
- i_rst_n  in  1  — reset, synchronous, active-low.
- i_req_valid  in  N_REQ  — bit k: requester k has an operation pending.
- o_req_ready  out  N_REQ  — bit k: requester k is accepted this cycle; at most one bit high.
- i_req_a  in  32*N_REQ  — operand A, requester k in bits [32k+31:32k].
- i_req_b  in  32*N_REQ  — operand B, same packing as i_req_a.
- i_req_sub  in  N_REQ  — bit k: 1 selects A−B, 0 selects A+B.
- o_rsp_valid  out  1  — response slot holds a result.
- i_rsp_ready  in  1  — consumer takes the response.
- o_rsp_id  out  ID_W  — index of the requester that issued the operation.
- o_rsp_sum  out  32  — result, modulo 2^32.
- o_rsp_carry  out  1  — adder carry-out.
- o_rsp_ovf  out  1  — two's-complement signed overflow.

## Operation
- Slot free: free = !o_rsp_valid || i_rsp_ready.
- Arbitration:
  - Round-robin, starting from pointer ptr.
  - The winner is the first k in the order ptr, ptr+1, …, N_REQ−1, 0, … with i_req_valid[k] = 1.
  - o_req_ready is the one-hot winner when free = 1; otherwise all zeros.
  - o_req_ready depends combinationally on i_req_valid and i_rsp_ready.
- Accept: i_req_valid[k] && o_req_ready[k].
  - On the next edge, ptr ← (k+1) mod N_REQ.
  - ptr holds its value in any cycle with no accept.
- Adder drive: the granted operands go combinationally into the single shared `ksa_top`.
  - i_a = A.
  - i_b = sub ? ~B : B.
  - c0 = sub.
  - There is no second adder and no adder logic outside `ksa_top`.
- Arithmetic:
  - {o_rsp_carry, o_rsp_sum} = A + (sub ? ~B : B) + sub, computed to 33 bits.
  - For subtraction, carry = 1 means no borrow (A ≥ B unsigned).
  - ovf = (A[31] == B'[31]) && (S[31] != A[31]), where B' is the inverted-or-not B.
- Response slot:
  - On accept, id, sum, carry and ovf are registered and o_rsp_valid ← 1.
  - On i_rsp_ready with no accept, o_rsp_valid ← 0.
  - While o_rsp_valid && !i_rsp_ready, every response output holds stable and no new grant is issued.
- Simultaneous consume and accept in the same cycle:
  - The slot reloads with the new result.
  - o_rsp_valid stays 1.
  - Throughput is 1 operation per cycle.
- Unused inputs: operand bits of non-granted requesters are ignored. i_req_sub[k] matters only when k is granted.
- Requester rule: a requester holds valid and its operands stable until accepted. The arbiter does not check this.

## Timing
- Reset (i_rst_n = 0 at an edge): ptr = 0, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_sum = 0, o_rsp_carry = 0, o_rsp_ovf = 0.
  - While reset is low, o_req_ready = 0.
  - Reset asserted mid-operation drops any pending response with no handshake.
  - The first grant after reset release favours requester 0.
- Latency: accept at edge N → o_rsp_valid = 1 with the result visible after edge N (cycle N+1).
- Critical path: i_req_valid → arbiter → operand mux → `ksa_top` → response register, all within one cycle.
- Fairness: with all N_REQ requesters continuously valid and the consumer always ready, grants rotate 0,1,…,N_REQ−1,0 with no gaps.
  - Any continuously valid requester is granted within N_REQ accepts.
- Stall: while the slot is full and the consumer is not ready, ptr is frozen.

## Test plan
- Reset then single add: req0 A = 0x0000_0005, B = 0x0000_0003, sub = 0.
  - Expect ready[0] in the same cycle.
  - Next cycle: rsp_valid = 1, id = 0, sum = 0x0000_0008, carry = 0, ovf = 0.
- Subtract and overflow, both via req2:
  - A = 3, B = 5, sub = 1 → sum = 0xFFFF_FFFE, carry = 0.
  - A = 0x7FFF_FFFF, B = 1, sub = 0 → sum = 0x8000_0000, ovf = 1.
  - A = 0xFFFF_FFFF, B = 1, sub = 0 → sum = 0, carry = 1, ovf = 0.
- All four requesters valid, consumer always ready, 8 cycles:
  - Grant order 0,1,2,3,0,1,2,3.
  - One response per cycle, ids matching that order.
- Backpressure: hold i_rsp_ready = 0 for 3 cycles with response id = 1 pending.
  - o_req_ready = 0 and the response outputs are unchanged throughout.
  - When ready rises, a new grant occurs in the same cycle (ptr = 2 → requester 2 wins if valid).
- Pointer skip: only req1 and req3 valid, ptr = 2.
  - Expect grant order 3,1,3,1; requesters 0 and 2 are never readied.
- Mid-operation reset: drop i_rst_n with rsp_valid = 1 and i_rsp_ready = 0.
  - Next cycle: all outputs 0, ptr = 0.
  - After release, a request on req3 alone is granted in the next cycle.
